lcd_spi_rx: RTL and testbench

//  Display-side responder for the 4-wire ILI9341 SPI link (SCK/MOSI/CS/DC) driven by the LCD interface.

---
 rtl/lcd_spi_pkg.sv | 31 +++
 rtl/lcd_spi_rx_byte.sv | 104 ++++++++++
 rtl/lcd_spi_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_lcd_spi_rx.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_pkg.sv
// ============================================================================
// lcd_spi_pkg
// ----------------------------------------------------------------------------
// Purpose:
//   Shared definitions for the ILI9341 SPI display-side responder: command
//   codes that steer the decoder, the decoder state type and the panel
//   geometry that seeds the address window out of reset.
//
// Contents:
//   CMD_CASET / CMD_PASET / CMD_RAMWR   command byte values
//   decState_e                          decoder state enum
//   PANEL_WIDTH / PANEL_HEIGHT          default panel size (240 x 320)
// ============================================================================
package lcd_spi_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int PANEL_WIDTH  = 240;
    localparam int PANEL_HEIGHT = 320;

    typedef enum logic [2:0] {
        IDLE,
        CASET,
        PASET,
        RAMWR,
        OTHER
    } decState_e;

endpackage

// File: rtl/lcd_spi_rx_byte.sv
// ============================================================================
// lcd_spi_rx_byte
// ----------------------------------------------------------------------------
// Purpose:
//   Oversamples the asynchronous 4-wire SPI link in the clk domain and turns
//   it into whole bytes. Every link wire passes through its own synchronizer
//   chain of equal depth, so SCK, MOSI, CS and DC stay aligned relative to
//   each other after synchronization. MOSI is shifted in on each synced SCK
//   rising edge while CS is low; DC is taken on the eighth edge.
//
// Parameters:
//   SYNC_STAGES   flops per input synchronizer (>= 2)
//
// Ports:
//   clk            in   system clock (>= 4x SCK)
//   rst            in   asynchronous, active-high reset
//   spi_sck        in   SPI clock, mode 0
//   spi_mosi       in   serial data, MSB first
//   spi_cs         in   chip select, active low
//   lcd_data_cmd   in   0 = command byte, 1 = data byte
//   byte_valid     out  1-cycle strobe on the eighth SCK rising edge
//   byte_data      out  assembled byte, valid with byte_valid
//   byte_is_data   out  DC level for the byte, valid with byte_valid
// ============================================================================
module lcd_spi_rx_byte
    import lcd_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs,
    input  logic       lcd_data_cmd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data
);

    logic [SYNC_STAGES-1:0] r_sckSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic [SYNC_STAGES-1:0] r_csSync;
    logic [SYNC_STAGES-1:0] r_dcSync;

    logic       r_sckPrev;
    logic [2:0] r_bitCnt;
    logic [6:0] r_shift;

    logic w_sck;
    logic w_mosi;
    logic w_cs;
    logic w_dc;
    logic w_sckRise;

    assign w_sck  = r_sckSync[SYNC_STAGES-1];
    assign w_mosi = r_mosiSync[SYNC_STAGES-1];
    assign w_cs   = r_csSync[SYNC_STAGES-1];
    assign w_dc   = r_dcSync[SYNC_STAGES-1];

    // A rising SCK only counts while the panel is selected; a deselected
    // link may toggle SCK for another device without disturbing us.
    assign w_sckRise = w_sck & ~r_sckPrev & ~w_cs;

    // Synchronizer chains for the four link wires. CS comes out of reset
    // deasserted so the shifter stays idle until the link really selects us.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sckSync  <= '0;
            r_mosiSync <= '0;
            r_csSync   <= '1;
            r_dcSync   <= '0;
            r_sckPrev  <= 1'b0;
        end else begin
            r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], spi_sck};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
            r_csSync   <= {r_csSync[SYNC_STAGES-2:0], spi_cs};
            r_dcSync   <= {r_dcSync[SYNC_STAGES-2:0], lcd_data_cmd};
            r_sckPrev  <= w_sck;
        end
    end

    // Bit counter and shifter. Deselecting the panel throws away any
    // partial byte by restarting the bit count; the stale shifter contents
    // are harmless because eight fresh bits always overwrite them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitCnt <= 3'd0;
            r_shift  <= 7'd0;
        end else if (w_cs) begin
            r_bitCnt <= 3'd0;
        end else if (w_sckRise) begin
            r_shift  <= {r_shift[5:0], w_mosi};
            r_bitCnt <= r_bitCnt + 3'd1;
        end
    end

    // The byte is presented combinationally on the eighth edge so the
    // decoder can register its pulse on the very next clock.
    assign byte_valid   = w_sckRise && (r_bitCnt == 3'd7);
    assign byte_data    = {r_shift, w_mosi};
    assign byte_is_data = w_dc;

endmodule

// File: rtl/lcd_spi_rx.sv
// ============================================================================
// lcd_spi_rx
// ----------------------------------------------------------------------------
// Purpose:
//   Display-side responder for the 4-wire ILI9341 SPI link. Deserializes
//   bytes, decodes commands and parameters, tracks the CASET/PASET address
//   window and turns RAMWR data into addressed RGB565 pixel writes. Used as
//   a framebuffer-capture display emulator and loopback checker.
//
// Parameters:
//   SYNC_STAGES   flops per input synchronizer (>= 2)
//   COORD_W       width of column/page coordinates
//
// Configuration macro:
//   LCD_SPI_RX_PXCNT_EN   when defined, px_count counts pixels since reset
//                         (wrapping at 2^32); otherwise px_count is tied 0.
//
// Ports:
//   clk, rst                      system clock, async active-high reset
//   spi_sck, spi_mosi, spi_cs     SPI link (mode 0, CS active low)
//   lcd_data_cmd                  0 = command byte, 1 = data byte
//   cmd_valid / cmd_code          command strobe / last command byte
//   param_valid / param_byte      parameter strobe / last parameter byte
//   px_valid / px_data            pixel strobe / {first byte, second byte}
//   px_x, px_y                    address of the pixel being written
//   win_xs, win_xe, win_ys, win_ye  current address window
//   px_count                      pixels written since reset
// ============================================================================
module lcd_spi_rx
    import lcd_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COORD_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    input  logic               spi_cs,
    input  logic               lcd_data_cmd,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic               param_valid,
    output logic [7:0]         param_byte,
    output logic               px_valid,
    output logic [15:0]        px_data,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [COORD_W-1:0] win_xs,
    output logic [COORD_W-1:0] win_xe,
    output logic [COORD_W-1:0] win_ys,
    output logic [COORD_W-1:0] win_ye,
    output logic [31:0]        px_count
);

    localparam logic [COORD_W-1:0] DEF_XE = COORD_W'(PANEL_WIDTH - 1);
    localparam logic [COORD_W-1:0] DEF_YE = COORD_W'(PANEL_HEIGHT - 1);

    logic       w_byteValid;
    logic [7:0] w_byteData;
    logic       w_byteIsData;

    decState_e          r_state;
    logic [1:0]         r_paramIdx;
    logic [23:0]        r_paramBuf;
    logic               r_pixPhase;
    logic [7:0]         r_hiByte;
    logic [COORD_W-1:0] r_curX;
    logic [COORD_W-1:0] r_curY;

    logic               r_cmdValid;
    logic [7:0]         r_cmdCode;
    logic               r_paramValid;
    logic [7:0]         r_paramByte;
    logic               r_pxValid;
    logic [15:0]        r_pxData;
    logic [COORD_W-1:0] r_pxX;
    logic [COORD_W-1:0] r_pxY;
    logic [COORD_W-1:0] r_winXs;
    logic [COORD_W-1:0] r_winXe;
    logic [COORD_W-1:0] r_winYs;
    logic [COORD_W-1:0] r_winYe;

    lcd_spi_rx_byte #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte (
        .clk          (clk),
        .rst          (rst),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_cs       (spi_cs),
        .lcd_data_cmd (lcd_data_cmd),
        .byte_valid   (w_byteValid),
        .byte_data    (w_byteData),
        .byte_is_data (w_byteIsData)
    );

    // Decoder FSM. Each received byte produces at most one strobe:
    // commands pick the next state, window parameters are collected until
    // all four bytes are in and then committed together, and RAMWR data is
    // paired into RGB565 pixels written at the cursor. Any command clears
    // the pixel phase, so a dangling high byte from an interrupted pixel is
    // dropped. Deselecting CS does not touch this state: only a new command
    // ends a memory write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_paramIdx   <= 2'd0;
            r_paramBuf   <= 24'd0;
            r_pixPhase   <= 1'b0;
            r_hiByte     <= 8'd0;
            r_curX       <= '0;
            r_curY       <= '0;
            r_cmdValid   <= 1'b0;
            r_cmdCode    <= 8'd0;
            r_paramValid <= 1'b0;
            r_paramByte  <= 8'd0;
            r_pxValid    <= 1'b0;
            r_pxData     <= 16'd0;
            r_pxX        <= '0;
            r_pxY        <= '0;
            r_winXs      <= '0;
            r_winXe      <= DEF_XE;
            r_winYs      <= '0;
            r_winYe      <= DEF_YE;
        end else begin
            r_cmdValid   <= 1'b0;
            r_paramValid <= 1'b0;
            r_pxValid    <= 1'b0;

            if (w_byteValid) begin
                if (!w_byteIsData) begin
                    r_cmdValid <= 1'b1;
                    r_cmdCode  <= w_byteData;
                    r_pixPhase <= 1'b0;
                    r_paramIdx <= 2'd0;
                    case (w_byteData)
                        CMD_CASET: r_state <= CASET;
                        CMD_PASET: r_state <= PASET;
                        CMD_RAMWR: begin
                            r_state <= RAMWR;
                            r_curX  <= r_winXs;
                            r_curY  <= r_winYs;
                        end
                        default:   r_state <= OTHER;
                    endcase
                end else begin
                    case (r_state)
                        CASET, PASET: begin
                            r_paramValid <= 1'b1;
                            r_paramByte  <= w_byteData;
                            if (r_paramIdx == 2'd3) begin
                                if (r_state == CASET) begin
                                    r_winXs <= COORD_W'(r_paramBuf[23:8]);
                                    r_winXe <= COORD_W'({r_paramBuf[7:0], w_byteData});
                                end else begin
                                    r_winYs <= COORD_W'(r_paramBuf[23:8]);
                                    r_winYe <= COORD_W'({r_paramBuf[7:0], w_byteData});
                                end
                                r_state <= OTHER;
                            end else begin
                                r_paramBuf <= {r_paramBuf[15:0], w_byteData};
                                r_paramIdx <= r_paramIdx + 2'd1;
                            end
                        end
                        RAMWR: begin
                            if (!r_pixPhase) begin
                                r_hiByte   <= w_byteData;
                                r_pixPhase <= 1'b1;
                            end else begin
                                r_pixPhase <= 1'b0;
                                r_pxValid  <= 1'b1;
                                r_pxData   <= {r_hiByte, w_byteData};
                                r_pxX      <= r_curX;
                                r_pxY      <= r_curY;
                                if (r_curX >= r_winXe) begin
                                    r_curX <= r_winXs;
                                    if (r_curY >= r_winYe) begin
                                        r_curY <= r_winYs;
                                    end else begin
                                        r_curY <= r_curY + 1'b1;
                                    end
                                end else begin
                                    r_curX <= r_curX + 1'b1;
                                end
                            end
                        end
                        default: begin
                            r_paramValid <= 1'b1;
                            r_paramByte  <= w_byteData;
                        end
                    endcase
                end
            end
        end
    end

`ifdef LCD_SPI_RX_PXCNT_EN
    logic [31:0] r_pxCount;

    // Running pixel total; it follows the registered pixel strobe and is
    // only ever cleared by reset, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pxCount <= 32'd0;
        end else if (r_pxValid) begin
            r_pxCount <= r_pxCount + 32'd1;
        end
    end

    assign px_count = r_pxCount;
`else
    assign px_count = 32'd0;
`endif

    assign cmd_valid   = r_cmdValid;
    assign cmd_code    = r_cmdCode;
    assign param_valid = r_paramValid;
    assign param_byte  = r_paramByte;
    assign px_valid    = r_pxValid;
    assign px_data     = r_pxData;
    assign px_x        = r_pxX;
    assign px_y        = r_pxY;
    assign win_xs      = r_winXs;
    assign win_xe      = r_winXe;
    assign win_ys      = r_winYs;
    assign win_ye      = r_winYe;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// ============================================================================
// tb_lcd_spi_rx
// ----------------------------------------------------------------------------
// Bench for lcd_spi_rx. Bytes are bit-banged onto the SPI link and every
// byte is predicted by a byte-count based model: the number of data bytes
// since the last command decides parameter vs pixel, and pixel addresses
// come from modulo arithmetic on the pixel index within the window.
// Honours LCD_SPI_RX_PXCNT_EN for the expected px_count.
// ============================================================================
module tb_lcd_spi_rx;

    localparam int SYNC_STAGES = 2;
    localparam int COORD_W     = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               spi_sck;
    logic               spi_mosi;
    logic               spi_cs;
    logic               lcd_data_cmd;
    logic               cmd_valid;
    logic [7:0]         cmd_code;
    logic               param_valid;
    logic [7:0]         param_byte;
    logic               px_valid;
    logic [15:0]        px_data;
    logic [COORD_W-1:0] px_x;
    logic [COORD_W-1:0] px_y;
    logic [COORD_W-1:0] win_xs;
    logic [COORD_W-1:0] win_xe;
    logic [COORD_W-1:0] win_ys;
    logic [COORD_W-1:0] win_ye;
    logic [31:0]        px_count;

    lcd_spi_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .COORD_W     (COORD_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_cs       (spi_cs),
        .lcd_data_cmd (lcd_data_cmd),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .param_valid  (param_valid),
        .param_byte   (param_byte),
        .px_valid     (px_valid),
        .px_data      (px_data),
        .px_x         (px_x),
        .px_y         (px_y),
        .win_xs       (win_xs),
        .win_xe       (win_xe),
        .win_ys       (win_ys),
        .win_ye       (win_ye),
        .px_count     (px_count)
    );

    always #5 clk = ~clk;

    int cycle = 0;

    // Free-running posedge counter used to time pulse latency.
    always @(posedge clk) cycle <= cycle + 1;

    int                 nCmd = 0;
    int                 nParam = 0;
    int                 nPx = 0;
    logic [7:0]         seenCmd;
    logic [7:0]         seenParam;
    logic [15:0]        seenPx;
    logic [COORD_W-1:0] seenX;
    logic [COORD_W-1:0] seenY;
    int                 seenCycle = 0;

    // Pulse monitor sampling on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cmd_valid) begin
            nCmd++;
            seenCmd = cmd_code;
            seenCycle = cycle;
        end
        if (param_valid) begin
            nParam++;
            seenParam = param_byte;
            seenCycle = cycle;
        end
        if (px_valid) begin
            nPx++;
            seenPx = px_data;
            seenX = px_x;
            seenY = px_y;
            seenCycle = cycle;
        end
    end

    int errCount = 0;
    int checkCount = 0;
    int lastRise = 0;

    int mLastCmd;
    int mDataCount;
    int mXs, mXe, mYs, mYe;
    int mBuf [4];
    int mHi;
    int mPixTotal;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mLastCmd = -1;
        mDataCount = 0;
        mXs = 0;
        mXe = 239;
        mYs = 0;
        mYe = 319;
        mHi = 0;
        mPixTotal = 0;
    endtask

    function automatic logic [31:0] expPxCount();
`ifdef LCD_SPI_RX_PXCNT_EN
        return 32'(mPixTotal);
`else
        return 32'd0;
`endif
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sendBits(input logic dc, input logic [7:0] value, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = value[7-i];
            lcd_data_cmd = dc;
            spi_sck = 1'b0;
            waitCycles(3);
            spi_sck = 1'b1;
            lastRise = cycle;
            waitCycles(3);
        end
        spi_sck = 1'b0;
        waitCycles(6);
    endtask

    task automatic applyStimulus(input logic dc, input logic [7:0] value);
        int c0, p0, x0, dC, dP, dX, obsKind, expKind, k, w, h;
        int expX, expY, expPx, s, e;
        expKind = 0;
        expX = 0;
        expY = 0;
        expPx = 0;
        if (!dc) begin
            expKind = 1;
            mLastCmd = int'(value);
            mDataCount = 0;
        end else begin
            if ((mLastCmd == 8'h2A || mLastCmd == 8'h2B) && mDataCount < 4) begin
                mBuf[mDataCount] = int'(value);
                expKind = 2;
                if (mDataCount == 3) begin
                    s = mBuf[0] * 256 + mBuf[1];
                    e = mBuf[2] * 256 + mBuf[3];
                    if (mLastCmd == 8'h2A) begin
                        mXs = s;
                        mXe = e;
                    end else begin
                        mYs = s;
                        mYe = e;
                    end
                end
            end else if (mLastCmd == 8'h2C) begin
                if (mDataCount % 2 == 0) begin
                    mHi = int'(value);
                end else begin
                    k = mDataCount / 2;
                    w = (mXe >= mXs) ? mXe - mXs + 1 : 1;
                    h = (mYe >= mYs) ? mYe - mYs + 1 : 1;
                    expX = mXs + k % w;
                    expY = mYs + (k / w) % h;
                    expPx = mHi * 256 + int'(value);
                    expKind = 3;
                    mPixTotal++;
                end
            end else begin
                expKind = 2;
            end
            mDataCount++;
        end

        c0 = nCmd;
        p0 = nParam;
        x0 = nPx;
        sendBits(dc, value, 8);
        dC = nCmd - c0;
        dP = nParam - p0;
        dX = nPx - x0;
        if (dC + dP + dX == 0)      obsKind = 0;
        else if (dC + dP + dX > 1)  obsKind = 4;
        else if (dC == 1)           obsKind = 1;
        else if (dP == 1)           obsKind = 2;
        else                        obsKind = 3;

        checkOutput("pulse_kind", 64'(obsKind), 64'(expKind));
        if (expKind == 1) checkOutput("cmd_code", 64'(seenCmd), 64'(value));
        if (expKind == 2) checkOutput("param_byte", 64'(seenParam), 64'(value));
        if (expKind == 3) begin
            checkOutput("px_data", 64'(seenPx), 64'(expPx));
            checkOutput("px_xy", {32'(seenX), 32'(seenY)}, {32'(expX), 32'(expY)});
        end
        if (expKind != 0 && obsKind == expKind)
            checkOutput("latency", 64'(seenCycle - lastRise), 64'(SYNC_STAGES + 1));
        checkOutput("win_x", {32'(win_xs), 32'(win_xe)}, {32'(mXs), 32'(mXe)});
        checkOutput("win_y", {32'(win_ys), 32'(win_ye)}, {32'(mYs), 32'(mYe)});
    endtask

    task automatic randomByte(input logic dc, input logic [7:0] value);
        if ($urandom_range(0, 5) == 0) begin
            spi_cs = 1'b1;
            waitCycles(4);
            spi_cs = 1'b0;
            waitCycles(4);
        end
        applyStimulus(dc, value);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_pulses"}, 64'({cmd_valid, param_valid, px_valid}), 64'd0);
        checkOutput({tag, "_codes"}, {48'(cmd_code), 16'(param_byte)}, 64'd0);
        checkOutput({tag, "_px"}, {16'(px_data), 16'(px_x), 32'(px_y)}, 64'd0);
        checkOutput({tag, "_win_x"}, {32'(win_xs), 32'(win_xe)}, {32'd0, 32'd239});
        checkOutput({tag, "_win_y"}, {32'(win_ys), 32'(win_ye)}, {32'd0, 32'd319});
        checkOutput({tag, "_px_count"}, 64'(px_count), 64'd0);
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, p0, x0, op, n;
        logic [7:0] v;

        rst = 1'b1;
        spi_sck = 1'b0;
        spi_mosi = 1'b0;
        spi_cs = 1'b1;
        lcd_data_cmd = 1'b0;
        modelReset();
        waitCycles(3);
        checkResetOutputs("reset");
        rst = 1'b0;
        waitCycles(2);
        spi_cs = 1'b0;
        waitCycles(4);

        $display("[TB] CASET window 10..19");
        applyStimulus(1'b0, 8'h2A);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h0A);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h13);
        checkOutput("caset_window", {32'(win_xs), 32'(win_xe)}, {32'd10, 32'd19});

        $display("[TB] 2x2 window pixel stream");
        applyStimulus(1'b0, 8'h2A);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b0, 8'h2B);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b0, 8'h2C);
        applyStimulus(1'b1, 8'hF8);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h07);
        applyStimulus(1'b1, 8'hE0);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h1F);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b1, 8'h12);
        applyStimulus(1'b1, 8'h34);
        checkOutput("wrap_to_origin", {32'(seenX), 32'(seenY)}, 64'd0);

        $display("[TB] command interrupting a pixel");
        applyStimulus(1'b0, 8'h2C);
        applyStimulus(1'b1, 8'hA1);
        applyStimulus(1'b1, 8'hB2);
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h2C);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);

        $display("[TB] partial byte discarded by CS");
        applyStimulus(1'b0, 8'h00);
        c0 = nCmd;
        p0 = nParam;
        x0 = nPx;
        sendBits(1'b1, 8'hFF, 5);
        checkOutput("partial_pulses", 64'((nCmd - c0) + (nParam - p0) + (nPx - x0)), 64'd0);
        spi_cs = 1'b1;
        waitCycles(5);
        spi_cs = 1'b0;
        waitCycles(4);
        applyStimulus(1'b1, 8'hAB);

        $display("[TB] randomized command stream");
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                randomByte(1'b0, (op <= 1) ? 8'h2A : 8'h2B);
                randomByte(1'b1, ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h00);
                randomByte(1'b1, 8'($urandom_range(0, 6)));
                randomByte(1'b1, 8'h00);
                randomByte(1'b1, 8'($urandom_range(0, 6)));
                if ($urandom_range(0, 3) == 0) randomByte(1'b1, 8'($urandom_range(0, 255)));
            end else if (op <= 7) begin
                randomByte(1'b0, 8'h2C);
                n = $urandom_range(0, 9);
                for (int j = 0; j < n; j++) randomByte(1'b1, 8'($urandom_range(0, 255)));
            end else if (op == 8) begin
                v = 8'($urandom_range(0, 255));
                if (v >= 8'h2A && v <= 8'h2C) v = 8'h00;
                randomByte(1'b0, v);
                n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) randomByte(1'b1, 8'($urandom_range(0, 255)));
            end else begin
                randomByte(1'b1, 8'($urandom_range(0, 255)));
            end
        end
        checkOutput("px_count_random", 64'(px_count), 64'(expPxCount()));

        $display("[TB] reset in the middle of RAMWR");
        applyStimulus(1'b0, 8'h2C);
        applyStimulus(1'b1, 8'h55);
        sendBits(1'b1, 8'hC3, 3);
        rst = 1'b1;
        #1;
        checkResetOutputs("mid_reset");
        waitCycles(2);
        rst = 1'b0;
        modelReset();
        waitCycles(4);
        applyStimulus(1'b1, 8'h12);
        applyStimulus(1'b1, 8'h34);

        $display("[TB] 100 pixel stream");
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        modelReset();
        waitCycles(4);
        applyStimulus(1'b0, 8'h2C);
        for (int j = 0; j < 200; j++) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
`ifdef LCD_SPI_RX_PXCNT_EN
        checkOutput("px_count_100", 64'(px_count), 64'd100);
`else
        checkOutput("px_count_100", 64'(px_count), 64'd0);
`endif
        checkOutput("px_count_model", 64'(px_count), 64'(expPxCount()));

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
